// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared pipeline types and constants for the fetch stage
package sys_defs;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] IR;
    logic [31:0] PC;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory request/response bus
interface if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/if_hold_buf.sv
// rtl/if_hold_buf.sv - one-entry holding buffer for a fetched word while ID stalls
module if_hold_buf
  import sys_defs::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   pop,
  input  logic   flush,
  input  if_id_t din,
  output if_id_t dout
);

  // dout.valid doubles as the occupancy flag
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      dout <= '0;
    end else if (load) begin
      dout <= din;
    end else if (pop) begin
      dout <= '0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, single-outstanding fetch FSM, IF/ID register
module if_stage
  import sys_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = sys_defs::NOP_INST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         id_stall_flag,
  input  logic         take_branch,
  input  logic [31:0]  branch_target_pc,
  if_stage_if.master   imem,
  output logic [31:0]  if_id_IR,
  output logic [31:0]  if_id_PC,
  output logic [31:0]  if_id_NPC,
  output logic         if_id_valid_inst
);

  fetch_state_t state, state_n;
  logic [31:0]  pc;
  if_id_t       if_id;
  if_id_t       hold;
  if_id_t       fetched;

  logic accepted;
  logic resp;
  logic in_flight;
  logic hold_load;
  logic hold_pop;

  assign imem.req  = (state == FETCH) && !hold.valid && !rst;
  assign imem.addr = pc;

  assign accepted = imem.req && imem.ready;
  assign resp     = (state == WAIT) && imem.rvalid;
  // A response is still owed to us after this cycle; it must be drained, not used
  assign in_flight = (((state == WAIT) || (state == DRAIN)) && !imem.rvalid) || accepted;

  assign fetched   = '{IR: imem.rdata, PC: pc, valid: 1'b1};
  assign hold_load = resp && id_stall_flag && !take_branch;
  assign hold_pop  = hold.valid && !id_stall_flag && !take_branch;

  if_hold_buf u_hold_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (hold_load),
    .pop   (hold_pop),
    .flush (take_branch),
    .din   (fetched),
    .dout  (hold)
  );

  always_comb begin
    state_n = state;
    if (take_branch) begin
      state_n = in_flight ? DRAIN : FETCH;
    end else begin
      case (state)
        FETCH:   if (accepted)     state_n = WAIT;
        WAIT:    if (imem.rvalid)  state_n = FETCH;
        DRAIN:   if (imem.rvalid)  state_n = FETCH;
        default:                   state_n = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= in_flight ? DRAIN : FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      if (take_branch) begin
        pc <= align_word(branch_target_pc);
      end else if (resp) begin
        pc <= pc + 32'd4;
      end
    end
  end

  // Bubbles keep the old PC; only IR and valid are meaningful for an empty slot
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id <= '{IR: NOP_INST, PC: 32'h0, valid: 1'b0};
    end else if (take_branch) begin
      if_id.IR    <= NOP_INST;
      if_id.valid <= 1'b0;
    end else if (!id_stall_flag) begin
      if (hold.valid) begin
        if_id <= hold;
      end else if (resp) begin
        if_id <= fetched;
      end else begin
        if_id.IR    <= NOP_INST;
        if_id.valid <= 1'b0;
      end
    end
  end

  assign if_id_IR         = if_id.IR;
  assign if_id_PC         = if_id.PC;
  assign if_id_NPC        = if_id.PC + 32'd4;
  assign if_id_valid_inst = if_id.valid;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized fetch-stage bench against a transaction-level reference model
module tb_if_stage;
  import sys_defs::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_stall_flag;
  logic        take_branch;
  logic [31:0] branch_target_pc;
  logic [31:0] if_id_IR;
  logic [31:0] if_id_PC;
  logic [31:0] if_id_NPC;
  logic        if_id_valid_inst;

  if_stage_if imem_bus();

  if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_stall_flag    (id_stall_flag),
    .take_branch      (take_branch),
    .branch_target_pc (branch_target_pc),
    .imem             (imem_bus),
    .if_id_IR         (if_id_IR),
    .if_id_PC         (if_id_PC),
    .if_id_NPC        (if_id_NPC),
    .if_id_valid_inst (if_id_valid_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
  } inst_t;

  // Reference model: next fetch address, one in-flight flag, and whether its reply is wrong-path
  inst_t       m_hold[$];
  inst_t       m_slot;
  logic        m_slot_valid;
  logic [31:0] m_pc;
  bit          m_busy;
  bit          m_drop;

  bit mem_pending;
  int mem_cnt;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input int p_rdy, input int p_stall, input int p_br, input int p_rst,
                       input int max_lat);
    logic  exp_req, acc, arrive, good, dut_acc;
    inst_t got;
    rst              = ($urandom_range(99) < p_rst);
    imem_bus.ready   = ($urandom_range(99) < p_rdy);
    id_stall_flag    = ($urandom_range(99) < p_stall);
    take_branch      = ($urandom_range(99) < p_br);
    branch_target_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                : $urandom;
    imem_bus.rvalid  = mem_pending && (mem_cnt == 0);
    imem_bus.rdata   = $urandom;
    #1;

    exp_req = !rst && !m_busy && (m_hold.size() == 0);
    chk("imem_req", 32'(imem_bus.req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_bus.addr, m_pc);
    chk("if_id_IR", if_id_IR, m_slot_valid ? m_slot.ir : NOP_INST);
    chk("if_id_valid", 32'(if_id_valid_inst), 32'(m_slot_valid));
    if (m_slot_valid) begin
      chk("if_id_PC", if_id_PC, m_slot.pc);
      chk("if_id_NPC", if_id_NPC, m_slot.pc + 32'd4);
    end

    if (rst) begin
      m_pc         = RESET_PC;
      m_slot       = '{ir: NOP_INST, pc: 32'h0};
      m_slot_valid = 1'b0;
      m_hold.delete();
      if (m_busy && !imem_bus.rvalid) m_drop = 1'b1;
      else begin m_busy = 1'b0; m_drop = 1'b0; end
    end else begin
      acc    = exp_req && imem_bus.ready;
      arrive = m_busy && imem_bus.rvalid;
      good   = arrive && !m_drop;
      if (take_branch) begin
        m_slot.ir    = NOP_INST;
        m_slot_valid = 1'b0;
        m_hold.delete();
        m_pc = {branch_target_pc[31:2], 2'b00};
        if ((m_busy && !imem_bus.rvalid) || acc) begin m_busy = 1'b1; m_drop = 1'b1; end
        else begin m_busy = 1'b0; m_drop = 1'b0; end
      end else begin
        got = '{ir: imem_bus.rdata, pc: m_pc};
        if (good) m_pc = m_pc + 32'd4;
        if (!id_stall_flag) begin
          if (m_hold.size() != 0) begin
            m_slot = m_hold.pop_front();
            m_slot_valid = 1'b1;
          end else if (good) begin
            m_slot = got;
            m_slot_valid = 1'b1;
          end else begin
            m_slot.ir    = NOP_INST;
            m_slot_valid = 1'b0;
          end
        end else if (good) begin
          m_hold.push_back(got);
        end
        if (arrive) begin m_busy = 1'b0; m_drop = 1'b0; end
        if (acc)    begin m_busy = 1'b1; m_drop = 1'b0; end
      end
    end

    dut_acc = imem_bus.req && imem_bus.ready;
    @(posedge clk);
    if (imem_bus.rvalid) mem_pending = 1'b0;
    else if (mem_pending) mem_cnt--;
    if (dut_acc) begin
      mem_pending = 1'b1;
      mem_cnt     = $urandom_range(max_lat, 0);
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input int p_rdy, input int p_stall, input int p_br,
                     input int p_rst, input int max_lat);
    for (int i = 0; i < n; i++) cycle(p_rdy, p_stall, p_br, p_rst, max_lat);
  endtask

  initial begin
    rst              = 1'b1;
    id_stall_flag    = 1'b0;
    take_branch      = 1'b0;
    branch_target_pc = 32'h0;
    imem_bus.ready   = 1'b1;
    imem_bus.rvalid  = 1'b0;
    imem_bus.rdata   = 32'h0;
    mem_pending      = 1'b0;
    mem_cnt          = 0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_req", 32'(imem_bus.req), 32'h0);
    chk("reset_IR", if_id_IR, 32'h0000_0013);
    chk("reset_PC", if_id_PC, 32'h0);
    chk("reset_NPC", if_id_NPC, 32'h4);
    chk("reset_valid", 32'(if_id_valid_inst), 32'h0);

    m_pc         = RESET_PC;
    m_slot       = '{ir: NOP_INST, pc: 32'h0};
    m_slot_valid = 1'b0;
    m_busy       = 1'b0;
    m_drop       = 1'b0;
    m_hold.delete();

    run(40,   100, 0,  0,  0, 0);
    run(200,  30,  0,  0,  0, 3);
    run(300,  70,  40, 0,  0, 2);
    run(400,  70,  20, 15, 0, 2);
    run(600,  60,  30, 10, 4, 3);
    run(2000, 60,  30, 10, 2, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction Fetch stage of the 5-stage in-order RISC-V pipeline.
- Owns the PC and issues one instruction-memory request at a time over a req/ready + rvalid handshake.
- Buffers one returned instruction while ID stalls; squashes wrong-path fetches on a branch/jump redirect.
- Drives the IF/ID pipeline register (IR, PC, valid) consumed directly by id_stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INST, 32'h0000_0013, IR value driven when the IF/ID slot is invalid (addi x0,x0,0).

Ports:
- clk  in  1  system clock
- rst  in  1  system reset
- id_stall_flag  in  1  ID hazard stall; IF/ID must hold its contents
- take_branch  in  1  redirect request from EX (taken cond branch, JAL, JALR)
- branch_target_pc  in  32  redirect target; bits [1:0] ignored, forced to 0
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response data valid; earliest is the cycle after acceptance
- imem_rdata  in  32  instruction word
- if_id_IR  out  32  instruction to ID
- if_id_PC  out  32  PC of if_id_IR
- if_id_NPC  out  32  if_id_PC + 4
- if_id_valid_inst  out  1  IF/ID slot holds a real instruction

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - pc = RESET_PC; state = FETCH; holding buffer empty.
  - if_id_IR = NOP_INST, if_id_PC = 0, if_id_NPC = 4, if_id_valid_inst = 0.
  - imem_req = 0 during the reset cycle.
  - Reset asserted mid-transaction abandons any outstanding response; rvalid arriving after reset deasserts is ignored for one pending response (state = DRAIN if a request was accepted, else FETCH).
- Outstanding requests: at most 1.
- imem_addr = pc whenever imem_req = 1. imem_req/imem_addr are stable until imem_ready.
- State FETCH:
  - imem_req = 1 unless the holding buffer is full.
  - On imem_ready: go to WAIT.
- State WAIT:
  - imem_req = 0.
  - On imem_rvalid, deliver the word. If the IF/ID slot is free or advancing (id_stall_flag = 0), load IF/ID: IR = rdata, PC = pc, valid = 1. Otherwise write {rdata, pc} into the 1-entry holding buffer.
  - In both cases pc += 4 (wraps modulo 2^32) and go to FETCH.
- State DRAIN:
  - imem_req = 0.
  - On imem_rvalid: discard the data, go to FETCH.
- IF/ID update when id_stall_flag = 0 and no redirect:
  - Holding buffer full → IF/ID takes the buffer entry and the buffer empties.
  - Else if a response is arriving → IF/ID takes the response.
  - Else → IF/ID becomes a bubble: IR = NOP_INST, valid = 0.
- id_stall_flag = 1 and no redirect: IF/ID holds all fields.
- Redirect (take_branch = 1) has priority over stall and over a same-cycle rvalid:
  - Next cycle: IF/ID = bubble, holding buffer emptied, pc = {branch_target_pc[31:2], 2'b00}.
  - Request accepted but not yet answered (WAIT without rvalid this cycle, or FETCH with imem_ready this cycle) → go to DRAIN.
  - Otherwise → go to FETCH, and request the target the following cycle.
- take_branch while already in DRAIN: update pc only, stay in DRAIN.
- Buffer full and another response pending: cannot happen. No request is issued while the buffer is full.
- if_id_NPC is combinational from if_id_PC + 4.
- Throughput: with zero-wait memory (ready = 1, rvalid the next cycle), 1 instruction every 2 cycles. No prefetch.

Decomposition:
- Shared package sys_defs: NOP_INST, fetch state enum {FETCH, WAIT, DRAIN} (2 bits), and an if_id_t struct {IR, PC, valid} used by the pipeline top.
- One sub-module: if_hold_buf (1-entry valid/data register with load/pop/flush).
- PC logic and the FSM stay in if_stage.

Test Plan:
- Reset with RESET_PC = 0, memory ready = 1, rvalid one cycle later → imem_addr sequence 0x0, 0x4, 0x8; if_id_PC 0x0, 0x4, 0x8 with valid = 1; bubbles (IR = 0x13, valid = 0) in between.
- Memory ready held low 3 cycles → imem_req/imem_addr = 0x0 stable all 3 cycles; single acceptance; no duplicate fetch.
- Stall: id_stall_flag = 1 while the response for 0x4 arrives → IF/ID holds 0x0; buffer holds 0x4; imem_req = 0. Release stall → IF/ID = 0x4 next cycle, then fetch of 0x8 proceeds.
- take_branch = 1 with target 0x103 while in WAIT for 0x8 → IF/ID bubble; the late rvalid (data 0xDEAD_BEEF) is discarded; next imem_addr = 0x100; IR 0xDEAD_BEEF never appears.
- take_branch in the same cycle as imem_rvalid, and simultaneously with id_stall_flag = 1 → response dropped; IF/ID bubble; next imem_addr = target.
- rst asserted in WAIT, then rvalid arrives 2 cycles after rst deasserts → that response is ignored; first valid IF/ID = RESET_PC with the subsequent data.
